// File: rtl/unroller.sv
// unroller: reassembles ROLL_NUM-element chunks into NUM-element vectors behind a valid/ready output register.
// Optional UNROLLER_FLUSH_EN adds a flush input that discards a partially assembled vector.
module unroller #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM        = 4,
  parameter int ROLL_NUM   = 2
) (
`ifdef UNROLLER_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in [ROLL_NUM],
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out [NUM],
  output logic                  data_out_valid,
  input  logic                  data_out_ready
);
  localparam int CHUNKS = NUM / ROLL_NUM;
  if (NUM % ROLL_NUM != 0) begin : g_bad
    $error("unroller: NUM must be a multiple of ROLL_NUM");
  end
`ifdef UNROLLER_FLUSH_EN
  logic flush_i;
  assign flush_i = flush;
`else
  localparam logic flush_i = 1'b0;
`endif
  logic                  last;
  logic                  load;
  logic [DATA_WIDTH-1:0] vec [NUM];
  if (CHUNKS == 1) begin : g_slice
    assign last = 1'b1;
    always_comb
      for (int j = 0; j < NUM; j++) vec[j] = data_in[j];
  end else begin : g_asm
    localparam int CW = $clog2(CHUNKS);
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] asm [NUM-ROLL_NUM];
    assign last = cnt == CW'(CHUNKS-1);
    always_comb begin
      for (int i = 0; i < NUM-ROLL_NUM; i++) vec[i] = asm[i];
      for (int j = 0; j < ROLL_NUM; j++) vec[NUM-ROLL_NUM+j] = data_in[j];
    end
    // the last chunk bypasses the buffer and goes straight into the output register
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        cnt <= '0;
        for (int i = 0; i < NUM-ROLL_NUM; i++) asm[i] <= '0;
      end else if (flush_i) begin
        cnt <= '0;
      end else if (data_in_valid && data_in_ready) begin
        cnt <= last ? '0 : cnt + CW'(1);
        for (int k = 0; k < CHUNKS-1; k++)
          if (cnt == CW'(k))
            for (int j = 0; j < ROLL_NUM; j++) asm[k*ROLL_NUM+j] <= data_in[j];
      end
  end
  assign data_in_ready = !(last && data_out_valid && !data_out_ready);
  assign load = data_in_valid && data_in_ready && last && !flush_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data_out_valid <= 1'b0;
      for (int i = 0; i < NUM; i++) data_out[i] <= '0;
    end else begin
      if (load)
        for (int i = 0; i < NUM; i++) data_out[i] <= vec[i];
      data_out_valid <= load || (data_out_valid && !data_out_ready);
    end
endmodule

// File: tb/tb_unroller.sv
// tb_unroller: directed vectors for unroller (4/2 and degenerate 4/4), plus a scoreboarded random run on the 4/4 slice.
module tb_unroller;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in [2];
  logic       data_in_valid = 1'b0;
  logic       data_in_ready;
  logic [7:0] data_out [4];
  logic       data_out_valid;
  logic       data_out_ready = 1'b1;
  logic       flush = 1'b0;
  logic [7:0] d1_in [4];
  logic       v1 = 1'b0;
  logic       r1;
  logic [7:0] d1_out [4];
  logic       ov1;
  logic       dor1 = 1'b1;
  logic [31:0] vec0, vec1;
  int vectors = 0;
  int errs = 0;
  logic [31:0] q[$];
  logic [31:0] rnd;
  logic        exp_r;

  always #5 clk = ~clk;

  unroller #(.DATA_WIDTH(8), .NUM(4), .ROLL_NUM(2)) dut (
`ifdef UNROLLER_FLUSH_EN
    .flush(flush),
`endif
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready), .data_out(data_out), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready));

  unroller #(.DATA_WIDTH(8), .NUM(4), .ROLL_NUM(4)) dut1 (
`ifdef UNROLLER_FLUSH_EN
    .flush(1'b0),
`endif
    .clk(clk), .rst(rst), .data_in(d1_in), .data_in_valid(v1),
    .data_in_ready(r1), .data_out(d1_out), .data_out_valid(ov1),
    .data_out_ready(dor1));

  assign vec0 = {data_out[0], data_out[1], data_out[2], data_out[3]};
  assign vec1 = {d1_out[0], d1_out[1], d1_out[2], d1_out[3]};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    data_in[0] = a;
    data_in[1] = b;
    data_in_valid = 1'b1;
  endtask

  initial begin
    data_in[0] = 8'h0; data_in[1] = 8'h0;
    for (int i = 0; i < 4; i++) d1_in[i] = 8'h0;
    #2;
    chk("rst_ready", data_in_ready, 1);
    chk("rst_valid", data_out_valid, 0);
    chk("rst_data", vec0, 0);
    @(negedge clk);
    rst = 1'b0;
    // single vector, ready held high
    step();
    send(8'h11, 8'h22);
    #1 chk("t1_ready0", data_in_ready, 1);
    step();
    chk("t1_novalid", data_out_valid, 0);
    send(8'h33, 8'h44);
    #1 chk("t1_ready1", data_in_ready, 1);
    step();
    chk("t1_valid", data_out_valid, 1);
    chk("t1_data", vec0, 32'h11223344);
    data_in_valid = 1'b0;
    step();
    chk("t1_drain", data_out_valid, 0);
    // back-to-back chunks
    send(8'd1, 8'd2);
    step();
    chk("t2_rdy_a", data_in_ready, 1);
    send(8'd3, 8'd4);
    step();
    chk("t2_valid_a", data_out_valid, 1);
    chk("t2_data_a", vec0, 32'h01020304);
    chk("t2_rdy_b", data_in_ready, 1);
    send(8'd5, 8'd6);
    step();
    chk("t2_gap", data_out_valid, 0);
    chk("t2_rdy_c", data_in_ready, 1);
    send(8'd7, 8'd8);
    step();
    chk("t2_valid_b", data_out_valid, 1);
    chk("t2_data_b", vec0, 32'h05060708);
    data_in_valid = 1'b0;
    step();
    chk("t2_drain", data_out_valid, 0);
    // output stalled
    data_out_ready = 1'b0;
    send(8'd1, 8'd2);
    step();
    send(8'd3, 8'd4);
    step();
    chk("t3_valid", data_out_valid, 1);
    chk("t3_data", vec0, 32'h01020304);
    send(8'd5, 8'd6);
    #1 chk("t3_rdy3", data_in_ready, 1);
    step();
    chk("t3_hold", vec0, 32'h01020304);
    send(8'd7, 8'd8);
    #1 chk("t3_rdy4", data_in_ready, 0);
    step();
    step();
    chk("t3_hold2", vec0, 32'h01020304);
    chk("t3_stall", data_in_ready, 0);
    data_out_ready = 1'b1;
    #1 chk("t3_rdy_up", data_in_ready, 1);
    step();
    chk("t3_valid_b", data_out_valid, 1);
    chk("t3_data_b", vec0, 32'h05060708);
    data_in_valid = 1'b0;
    step();
    chk("t3_drain", data_out_valid, 0);
    chk("t3_retain", vec0, 32'h05060708);
    // async reset mid-vector
    send(8'hAA, 8'hBB);
    step();
    data_in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t4_valid", data_out_valid, 0);
    chk("t4_data", vec0, 0);
    chk("t4_ready", data_in_ready, 1);
    #1 rst = 1'b0;
    step();
    send(8'd1, 8'd2);
    step();
    chk("t4_partial", data_out_valid, 0);
    send(8'd3, 8'd4);
    step();
    chk("t4_valid2", data_out_valid, 1);
    chk("t4_data2", vec0, 32'h01020304);
    data_in_valid = 1'b0;
    step();
`ifdef UNROLLER_FLUSH_EN
    send(8'd9, 8'd9);
    step();
    data_in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    send(8'd1, 8'd2);
    step();
    chk("t5_partial", data_out_valid, 0);
    send(8'd3, 8'd4);
    step();
    chk("t5_data", vec0, 32'h01020304);
    data_out_ready = 1'b0;
    send(8'd5, 8'd6);
    step();
    send(8'd7, 8'd8);
    flush = 1'b1;
    step();
    flush = 1'b0;
    data_in_valid = 1'b0;
    chk("t5_held_v", data_out_valid, 1);
    chk("t5_held_d", vec0, 32'h01020304);
    data_out_ready = 1'b1;
    step();
    chk("t5_drain", data_out_valid, 0);
    send(8'h21, 8'h22);
    step();
    chk("t5_partial2", data_out_valid, 0);
    send(8'h23, 8'h24);
    step();
    chk("t5_data2", vec0, 32'h21222324);
    data_in_valid = 1'b0;
    step();
`endif
    // degenerate single-chunk slice
    d1_in[0] = 8'd1; d1_in[1] = 8'd2; d1_in[2] = 8'd3; d1_in[3] = 8'd4;
    v1 = 1'b1;
    #1 chk("t6_ready", r1, 1);
    step();
    chk("t6_valid", ov1, 1);
    chk("t6_data", vec1, 32'h01020304);
    v1 = 1'b0;
    step();
    chk("t6_drain", ov1, 0);
    for (int n = 0; n < 100; n++) begin
      rnd = $urandom;
      for (int i = 0; i < 4; i++) d1_in[i] = 8'($urandom);
      v1 = rnd[0] | rnd[1];
      dor1 = rnd[2] | rnd[3];
      #1;
      exp_r = !(q.size() != 0 && !dor1);
      chk("t6_rnd_ready", r1, exp_r);
      chk("t6_rnd_valid", ov1, q.size() != 0);
      if (ov1 && q.size() != 0) chk("t6_rnd_data", vec1, q[0]);
      if (q.size() != 0 && dor1) void'(q.pop_front());
      if (v1 && exp_r) q.push_back({d1_in[0], d1_in[1], d1_in[2], d1_in[3]});
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
